// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//
// Round-robin APB master. NUM_REQ internal requesters share one APB bus; one
// command is in flight at a time. The winner's command is sequenced through
// the APB SETUP and ACCESS phases. Read data, or a timeout error, is returned
// to the winner as a single-cycle one-hot completion pulse. A programmable
// PREADY timeout aborts transfers to a hung slave. TIMEOUT = 0 disables it.
//
// Ports
//   PCLK, PRESET           clock, synchronous active-high reset
//   req_valid/req_write    per-requester command valid and direction
//   req_addr/req_wdata     packed per-requester address and write data
//                          (requester i at [i*W +: W])
//   req_ready              one-hot accept, combinational, only in IDLE
//   rsp_valid              one-hot completion pulse
//   rsp_rdata/rsp_err      read data and timeout flag, valid with rsp_valid
//   PADDR..PENABLE         APB master outputs (all registered)
//   PRDATA, PREADY         APB slave returns
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    output logic                          PWRITE,
    output logic                          PSEL,
    output logic                          PENABLE,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // A zero TIMEOUT would give a zero-width counter; keep one bit so the
    // declaration stays legal. The compare branch is dead in that case.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0]   LAST_GRANT_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST       = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0]   CNT_MAX        = {CNT_W{1'b1}};
    localparam logic [NUM_REQ-1:0] ONE_HOT0       = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_r;
    logic [IDX_W-1:0]      last_grant_r;
    logic [IDX_W-1:0]      winner_r;
    logic [CNT_W-1:0]      wait_cnt_r;
    logic [IDX_W:0]        pick_s;
    logic                  grant_s;
    logic [IDX_W-1:0]      grant_idx_s;
    logic [ADDR_WIDTH-1:0] addr_s  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_s [NUM_REQ];

    // Round-robin search starting at last+1. Scanning from the farthest
    // candidate to the nearest lets the nearest valid requester overwrite
    // any earlier hit, so it wins. Result is {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx_v;
        res = {(IDX_W+1){1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_v = IDX_W'((int'(last) + k) % NUM_REQ);
            if (valid[idx_v]) begin
                res = {1'b1, idx_v};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_s[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_s[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Arbitration: winner among the currently valid requesters.
    always_comb begin
        pick_s      = rr_pick(req_valid, last_grant_r);
        grant_s     = pick_s[IDX_W];
        grant_idx_s = pick_s[IDX_W-1:0];
    end

    // Accept pulse: only while idle and out of reset, so a command is never
    // acknowledged on an edge that discards it.
    always_comb begin
        if (!PRESET && (state_r == ST_IDLE) && grant_s) begin
            req_ready = ONE_HOT0 << grant_idx_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // APB sequencing FSM with registered bus and response outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r      <= ST_IDLE;
            last_grant_r <= LAST_GRANT_RST;
            winner_r     <= {IDX_W{1'b0}};
            wait_cnt_r   <= {CNT_W{1'b0}};
            PADDR        <= {ADDR_WIDTH{1'b0}};
            PWDATA       <= {DATA_WIDTH{1'b0}};
            PWRITE       <= 1'b0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            rsp_valid    <= {NUM_REQ{1'b0}};
            rsp_rdata    <= {DATA_WIDTH{1'b0}};
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid <= {NUM_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        PADDR        <= addr_s[grant_idx_s];
                        PWDATA       <= wdata_s[grant_idx_s];
                        PWRITE       <= req_write[grant_idx_s];
                        PSEL         <= 1'b1;
                        last_grant_r <= grant_idx_s;
                        winner_r     <= grant_idx_s;
                        state_r      <= ST_SETUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    PENABLE    <= 1'b1;
                    wait_cnt_r <= {CNT_W{1'b0}};
                    state_r    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? {DATA_WIDTH{1'b0}} : PRDATA;
                        rsp_err   <= 1'b0;
                        rsp_valid <= ONE_HOT0 << winner_r;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (wait_cnt_r == CNT_LAST)) begin
                        rsp_rdata <= {DATA_WIDTH{1'b0}};
                        rsp_err   <= 1'b1;
                        rsp_valid <= ONE_HOT0 << winner_r;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (wait_cnt_r != CNT_MAX) begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
